// File: rtl/wb_slave_decode_mux.sv
// wb_slave_decode_mux
// Wishbone classic interconnect: one master fanned out to NUM_SLAVES slaves.
// Slave selection is decoded once per transaction and held in sel_q. Unmapped
// addresses get an error response from a built-in responder. Slaves that never
// ack are aborted after TIMEOUT_CYCLES with an error response. The first error
// since the last clear is held in sticky registers for firmware to read.
module wb_slave_decode_mux #(
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h000F_0000, 32'h000E_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'h000F_FF00, 32'h000F_FF00},
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             m_cyc_i,
    input  logic                             m_stb_i,
    input  logic                             m_we_i,
    input  logic [ADDR_WIDTH-1:0]            m_adr_i,
    input  logic [DATA_WIDTH-1:0]            m_dat_i,
    input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
    output logic                             m_ack_o,
    output logic                             m_err_o,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic [NUM_SLAVES-1:0]            s_cyc_o,
    output logic [NUM_SLAVES-1:0]            s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic [DATA_WIDTH/8-1:0]          s_sel_o,
    input  logic [NUM_SLAVES-1:0]            s_ack_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
    output logic                             err_valid_o,
    output logic [1:0]                       err_cause_o,
    output logic [ADDR_WIDTH-1:0]            err_addr_o,
    input  logic                             err_clear_i
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep the counter one bit wide then.
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_WIDTH  = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LAST_I = TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_LAST_I);

    localparam logic [1:0] CAUSE_MISS    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   match;
    logic [NUM_SLAVES-1:0]   first_hit;
    logic                    any_hit;
    logic                    sel_ack;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    timeout_hit;
    logic                    err_event;
    logic [1:0]              err_cause_d;
    logic                    err_valid_q;
    logic [1:0]              err_cause_q;
    logic [ADDR_WIDTH-1:0]   err_addr_q;

    // Address, write data, write enable and byte enables go to every slave unchanged.
    assign s_we_o  = m_we_i;
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;

    assign err_valid_o = err_valid_q;
    assign err_cause_o = err_cause_q;
    assign err_addr_o  = err_addr_q;

    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // Base/mask match for every slave, reduced to a one-hot of the lowest matching index.
    always_comb begin
        match     = '0;
        first_hit = '0;
        any_hit   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match[i] = ((m_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                        (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
            if (match[i] && !any_hit) begin
                first_hit[i] = 1'b1;
                any_hit      = 1'b1;
            end
        end
    end

    // Ack and read data of the slave held in sel_q (one-hot, so an OR-reduction suffices).
    always_comb begin
        sel_ack = |(s_ack_i & sel_q);
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_dat = sel_dat | s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State, selection and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and master/slave handshake outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = '0;
        err_event   = 1'b0;
        err_cause_d = 2'b00;
        m_ack_o     = 1'b0;
        m_err_o     = 1'b0;
        m_dat_o     = '0;
        s_cyc_o     = '0;
        s_stb_o     = '0;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    sel_d = first_hit;
                    if (any_hit) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d     = RESP;
                        err_event   = 1'b1;
                        err_cause_d = CAUSE_MISS;
                    end
                end
            end
            ACTIVE: begin
                s_cyc_o = sel_q & {NUM_SLAVES{m_cyc_i}};
                s_stb_o = sel_q & {NUM_SLAVES{m_cyc_i & m_stb_i}};
                m_ack_o = sel_ack;
                m_dat_o = sel_dat;
                if (!m_cyc_i || sel_ack) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    err_event   = 1'b1;
                    err_cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                m_ack_o = m_cyc_i;
                m_err_o = m_cyc_i;
                m_dat_o = ERR_DATA;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error capture: first error wins, unless a clear lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_cause_q <= 2'b00;
            err_addr_q  <= '0;
        end else if (err_event && (!err_valid_q || err_clear_i)) begin
            err_valid_q <= 1'b1;
            err_cause_q <= err_cause_d;
            err_addr_q  <= m_adr_i;
        end else if (err_clear_i) begin
            err_valid_q <= 1'b0;
            err_cause_q <= 2'b00;
            err_addr_q  <= '0;
        end
    end

endmodule

// File: tb/tb_wb_slave_decode_mux.sv
// tb_wb_slave_decode_mux
// Drives Wishbone transactions from the master side, plays the slaves, and
// compares the DUT against a transaction-level model of decode, latency and
// sticky error capture. Uses TIMEOUT_CYCLES=4 so timeouts are short.
module tb_wb_slave_decode_mux;

    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
    logic [31:0] m_adr_i = '0, m_dat_i = '0;
    logic [3:0]  m_sel_i = '0;
    logic        m_ack_o, m_err_o;
    logic [31:0] m_dat_o;
    logic [1:0]  s_cyc_o, s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  s_ack_i = '0;
    logic [63:0] s_dat_i = '0;
    logic        err_valid_o;
    logic [1:0]  err_cause_o;
    logic [31:0] err_addr_o;
    logic        err_clear_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference copy of the sticky error registers.
    logic        mv = 1'b0;
    logic [1:0]  mc = 2'b00;
    logic [31:0] ma = '0;

    wb_slave_decode_mux #(
        .NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .err_valid_o(err_valid_o), .err_cause_o(err_cause_o),
        .err_addr_o(err_addr_o), .err_clear_i(err_clear_i)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Slave 0 owns 0x?00E00xx, slave 1 owns 0x?00F00xx: bits [19:8] select the window.
    function automatic int ref_decode(input logic [31:0] a);
        logic [31:0] base;
        ref_decode = -1;
        for (int i = 0; i < 2; i++) begin
            base = (i == 0) ? 32'h000E_0000 : 32'h000F_0000;
            if (ref_decode < 0 && a[19:8] == base[19:8]) ref_decode = i;
        end
    endfunction

    task automatic master_idle();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; err_clear_i = 1'b0; s_ack_i = '0;
    endtask

    task automatic check_err_regs(input string name);
        n_cmp++;
        if ({err_valid_o, err_cause_o, err_addr_o} !== {mv, mc, ma}) begin
            n_bad++;
            $display("[TB] FAIL %s err regs got v=%b c=%b a=%h exp v=%b c=%b a=%h",
                     name, err_valid_o, err_cause_o, err_addr_o, mv, mc, ma);
        end
    endtask

    // One full master transaction. lat = strobe cycle on which the slave acks (<=0: never).
    // clr_cyc = transaction cycle during which err_clear_i is pulsed (0: none).
    task automatic run_txn(input string name, input logic [31:0] adr, input logic we,
                           input logic [31:0] wdat, input int lat, input logic [31:0] rdat,
                           input int clr_cyc);
        int          idx, last, stb_last;
        logic        is_err;
        logic [1:0]  cause;
        logic [3:0]  sel;
        logic [1:0]  exp_stb;
        logic [31:0] exp_dat;
        idx = ref_decode(adr);
        sel = 4'($urandom);
        if (idx < 0) begin
            is_err = 1'b1; cause = 2'b01; last = 2; stb_last = 0;
        end else if (lat >= 1 && lat <= T) begin
            is_err = 1'b0; cause = 2'b00; last = 1 + lat; stb_last = last;
        end else begin
            is_err = 1'b1; cause = 2'b10; last = T + 2; stb_last = T + 1;
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
            m_adr_i = adr; m_dat_i = wdat; m_sel_i = sel;
            err_clear_i = (c == clr_cyc);
            s_ack_i = 2'($urandom);
            s_dat_i = {$urandom, $urandom};
            if (idx >= 0) begin
                s_ack_i[idx] = (lat > 0 && c == 1 + lat);
                s_dat_i[idx*32 +: 32] = rdat;
            end
            #1;
            exp_stb = (idx >= 0 && c >= 2 && c <= stb_last) ? 2'(1 << idx) : 2'b00;
            exp_dat = (c == 1) ? 32'h0 : ((is_err && c == last) ? ERR : rdat);
            n_cmp++;
            if ({m_ack_o, m_err_o} !== {c == last, is_err && c == last}) begin
                n_bad++;
                $display("[TB] FAIL %s ack/err cycle %0d got %b%b exp %b%b", name, c,
                         m_ack_o, m_err_o, c == last, is_err && c == last);
            end
            n_cmp++;
            if (s_stb_o !== exp_stb || s_cyc_o !== exp_stb) begin
                n_bad++;
                $display("[TB] FAIL %s slave strobes cycle %0d got cyc=%b stb=%b exp %b",
                         name, c, s_cyc_o, s_stb_o, exp_stb);
            end
            n_cmp++;
            if (m_dat_o !== exp_dat) begin
                n_bad++;
                $display("[TB] FAIL %s m_dat_o cycle %0d got %h exp %h", name, c, m_dat_o, exp_dat);
            end
            n_cmp++;
            if ({s_we_o, s_adr_o, s_dat_o, s_sel_o} !== {we, adr, wdat, sel}) begin
                n_bad++;
                $display("[TB] FAIL %s broadcast cycle %0d got %b %h %h %h", name, c,
                         s_we_o, s_adr_o, s_dat_o, s_sel_o);
            end
            if (is_err && c == last - 1 && (!mv || c == clr_cyc)) begin
                mv = 1'b1; mc = cause; ma = adr;
            end else if (c == clr_cyc) begin
                mv = 1'b0; mc = 2'b00; ma = '0;
            end
        end
        @(negedge clk);
        master_idle();
        #1;
        n_cmp++;
        if (m_ack_o !== 1'b0 || s_stb_o !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL %s after-txn got ack=%b stb=%b exp 0 00", name, m_ack_o, s_stb_o);
        end
        check_err_regs(name);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        master_idle();
        err_clear_i = 1'b1;
        @(negedge clk);
        err_clear_i = 1'b0;
        mv = 1'b0; mc = 2'b00; ma = '0;
        #1;
        check_err_regs("err_clear");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        master_idle();
        #12;
        n_cmp++;
        if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_dat_o} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset outputs got cyc=%b stb=%b ack=%b err=%b dat=%h exp all 0",
                     s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_dat_o);
        end
        check_err_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_abort();
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h000F_0020;
        s_ack_i = 2'b00;
        @(negedge clk);
        #1;
        n_cmp++;
        if (s_stb_o !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL abort active strobe got %b exp 10", s_stb_o);
        end
        @(negedge clk);
        m_cyc_i = 1'b0;
        #1;
        n_cmp++;
        if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== 6'b0) begin
            n_bad++;
            $display("[TB] FAIL abort drop got cyc=%b stb=%b ack=%b err=%b exp 0",
                     s_cyc_o, s_stb_o, m_ack_o, m_err_o);
        end
        @(negedge clk);
        master_idle();
        #1;
        n_cmp++;
        if ({s_stb_o, m_ack_o} !== 3'b0) begin
            n_bad++;
            $display("[TB] FAIL abort idle got stb=%b ack=%b exp 0", s_stb_o, m_ack_o);
        end
        check_err_regs("abort");
        run_txn("after_abort", 32'h000F_0030, 1'b0, 32'h0, 3, 32'h5A5A_0003, 0);
    endtask

    task automatic test_resp_cyc_low();
        pulse_clear();
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0002_3400;
        @(negedge clk);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        #1;
        n_cmp++;
        if (m_ack_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL resp_cyc_low ack got %b exp 0", m_ack_o);
        end
        mv = 1'b1; mc = 2'b01; ma = 32'h0002_3400;
        @(negedge clk);
        #1;
        check_err_regs("resp_cyc_low");
    endtask

    task automatic test_random(input int n);
        logic [31:0] adr;
        int          kind;
        for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: adr = 32'h000E_0000 | 32'($urandom_range(0, 255)) | ($urandom & 32'hFFF0_0000);
                1: adr = 32'h000F_0000 | 32'($urandom_range(0, 255));
                2: adr = $urandom;
                default: adr = 32'h000E_0100 | 32'($urandom_range(0, 255));
            endcase
            run_txn("random", adr, 1'($urandom), $urandom, $urandom_range(0, 6), $urandom,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
        end
    endtask

    task automatic test_reset_mid_active();
        run_txn("pre_reset_miss", 32'h0005_0000, 1'b0, 32'h0, 1, 32'h0, 0);
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h000E_0040;
        s_ack_i = 2'b00; s_dat_i = {32'h1111_2222, 32'h3333_4444};
        @(negedge clk);
        #1;
        n_cmp++;
        if (s_stb_o !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL reset_mid pre strobe got %b exp 01", s_stb_o);
        end
        #2;
        rst_n = 1'b0;
        s_ack_i = 2'b11;
        #1;
        mv = 1'b0; mc = 2'b00; ma = '0;
        n_cmp++;
        if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_dat_o} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid outputs got cyc=%b stb=%b ack=%b err=%b dat=%h exp all 0",
                     s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_dat_o);
        end
        check_err_regs("reset_mid");
        @(negedge clk);
        master_idle();
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("post_reset_s1", 32'h000F_0080, 1'b0, 32'h0, 2, 32'hBEEF_0080, 0);
    endtask

    // Bounds the whole run in case the DUT or bench wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        run_txn("write_slave0", 32'h000E_0004, 1'b1, 32'h1234_5678, 2, 32'h0000_0000, 0);
        run_txn("read_slave1", 32'h000F_0010, 1'b0, 32'h0, 1, 32'hCAFE_0001, 0);
        run_txn("decode_miss", 32'h0001_0000, 1'b0, 32'h0, 1, 32'h0, 0);
        pulse_clear();
        run_txn("timeout", 32'h000E_0008, 1'b0, 32'h0, 0, 32'h7777_0008, 0);
        run_txn("second_miss", 32'h0003_0000, 1'b1, 32'hABCD_0000, 1, 32'h0, 0);
        pulse_clear();
        run_txn("ack_at_threshold", 32'h000E_000C, 1'b0, 32'h0, T, 32'h600D_000C, 0);
        test_abort();
        test_resp_cyc_low();
        run_txn("clear_collision", 32'h0004_0000, 1'b0, 32'h0, 1, 32'h0, 1);
        test_random(60);
        test_reset_mid_active();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_decode_mux.md
# wb_slave_decode_mux

Parametrised Wishbone classic interconnect that connects one master (the SoC's WB output port) to NUM_SLAVES peripheral slaves, such as the wfg timer. Address decode uses per-slave base/mask pairs. The block adds three behaviours that plain combinational muxing lacks:
- a registered slave selection that holds for the whole cycle;
- a built-in default responder for unmapped addresses;
- a per-transaction ack timeout, with sticky error capture for firmware.

## Interface
Parameters:
- NUM_SLAVES, 2, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- SLAVE_BASE, {32'h000F_0000, 32'h000E_0000}, packed NUM_SLAVES×ADDR_WIDTH; entry i = base of slave i
- SLAVE_MASK, {32'h000F_FF00, 32'h000F_FF00}, packed; slave i matches when (adr & MASK[i]) == (BASE[i] & MASK[i])
- TIMEOUT_CYCLES, 255, ACTIVE cycles without ack before abort; 0 disables timeout
- ERR_DATA, 32'hDEAD_BEEF, read data returned on decode error or timeout

Ports:
- clk  in  1  clock (single domain)
- rst_n  in  1  reset: asynchronous and active-low
- m_cyc_i, m_stb_i, m_we_i  in  1  master cycle, strobe, write enable
- m_adr_i  in  ADDR_WIDTH  master address
- m_dat_i  in  DATA_WIDTH  master write data
- m_sel_i  in  DATA_WIDTH/8  byte enables
- m_ack_o  out  1  ack to master
- m_err_o  out  1  qualifies m_ack_o as error response
- m_dat_o  out  DATA_WIDTH  read data to master
- s_cyc_o, s_stb_o  out  NUM_SLAVES  per-slave cycle and strobe
- s_we_o, s_adr_o, s_dat_o, s_sel_o  out  1/ADDR/DATA/SEL  broadcast copies of master signals
- s_ack_i  in  NUM_SLAVES  per-slave ack
- s_dat_i  in  NUM_SLAVES×DATA_WIDTH  per-slave read data, slave i at [i*DW +: DW]
- err_valid_o  out  1  sticky: an error has been captured
- err_cause_o  out  2  01 decode miss, 10 timeout, 00 none
- err_addr_o  out  ADDR_WIDTH  address of the first captured error
- err_clear_i  in  1  synchronous clear of the err_* registers

## Operation
States: IDLE, ACTIVE, RESP.

IDLE
- On m_cyc_i & m_stb_i, decode m_adr_i.
- The lowest matching index wins.
- Register sel_q (one-hot) and transition:
  - any match → ACTIVE;
  - no match → RESP, cause=decode miss.

ACTIVE
- s_cyc_o[sel] = m_cyc_i and s_stb_o[sel] = m_stb_i; all other slave strobes are 0.
- m_ack_o = s_ack_i[sel] (combinational); m_dat_o = s_dat_i[sel]; m_err_o = 0.
- On ack: return to IDLE next cycle.
- If m_cyc_i drops: abort, return to IDLE, strobes drop the same cycle, no error.

Timeout
- Counter clears on entry to ACTIVE and increments each ACTIVE cycle with no ack.
- When count == TIMEOUT_CYCLES-1 and no ack: go to RESP with cause=timeout. Slave strobes deassert from the next cycle.
- Ack in that same cycle wins; no error.

RESP
- m_ack_o=1, m_err_o=1, m_dat_o=ERR_DATA for exactly one cycle, then IDLE.
- If m_cyc_i is low in RESP, the ack is suppressed, the block returns to IDLE, and the error is still captured.

Error capture
- On entry to RESP, if err_valid_o=0: latch address and cause, set err_valid_o.
- Later errors do not overwrite the first.
- err_clear_i clears all err_* registers. A new error arriving in the same cycle wins: it is captured, err_valid_o stays 1.

Width rules
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1).
- Masks compare the full ADDR_WIDTH.

## Timing
- Reset (async, rst_n=0): state=IDLE, sel_q=0, counter=0, all s_cyc_o/s_stb_o=0, m_ack_o=0, m_err_o=0, m_dat_o=0, err_valid_o=0, err_cause_o=0, err_addr_o=0.
- Reset asserted mid-transaction drops all strobes immediately, without waiting for a clock edge.
- Decode latency: 1 cycle. The master strobe at edge N produces the slave strobe after edge N+1.
- Mapped access total: 1 cycle plus the slave's ack latency.
- Decode miss: ack is high in the cycle after the decode edge (2 cycles from strobe).
- Timeout: error ack is high TIMEOUT_CYCLES+1 cycles after ACTIVE entry.
- At most one outstanding transaction; pipelined Wishbone is not supported.

## Test plan
- Write 32'h1234_5678 to 32'h000E_0004 with slave0 acking 2 cycles after strobe → s_stb_o=01 for 2 cycles; m_ack_o=1, m_err_o=0; slave1 strobes stay 0.
- Read 32'h000F_0010 with slave1 returning 32'hCAFE_0001 → m_dat_o=32'hCAFE_0001 with ack; sel_q=10.
- Read unmapped 32'h0001_0000 → m_ack_o=1, m_err_o=1, m_dat_o=32'hDEAD_BEEF 2 cycles after strobe; err_valid_o=1, err_cause_o=01, err_addr_o=32'h0001_0000.
- Slave0 never acks, TIMEOUT_CYCLES=4 → error ack on the 5th cycle after ACTIVE entry. Then a second miss leaves err_addr_o and err_cause_o unchanged. err_clear_i pulse → err_valid_o=0.
- Slave ack in the same cycle as the timeout threshold → normal ack, m_err_o=0, err_valid_o unchanged.
- rst_n low mid-ACTIVE → all outputs 0 asynchronously. After release, a new access to slave1 completes normally.
